// File: rtl/rv32_pkg.sv
// Shared RV32 constants: data width, canonical NOP encoding and fetch fault codes.
package rv32_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [1:0] fault_t;

   localparam fault_t FAULT_NONE     = 2'd0;
   localparam fault_t FAULT_MISALIGN = 2'd1;
   localparam fault_t FAULT_RANGE    = 2'd2;

   // Misalignment is reported ahead of range so a bad PC gets one stable code.
   function automatic fault_t classify_pc(input logic [1:0] low_bits, input logic above_range);
      if (low_bits != 2'b00) return FAULT_MISALIGN;
      if (above_range)       return FAULT_RANGE;
      return FAULT_NONE;
   endfunction

endpackage

// File: rtl/fetch_rsp_fifo2.sv
// Two-entry in-order response FIFO; push and pop may coincide in one cycle.
// Flush and reset both empty it at the next edge; stored words are not cleared.
module fetch_rsp_fifo2 #(
   parameter int W = 66
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] slot [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !flush && push) slot[wr_ptr] <= push_data;
   end

   assign head  = slot[rd_ptr];
   assign count = cnt;

   assert property (@(posedge clk) disable iff (reset || flush)
                    !(push && !pop && cnt == 2'd2));
   assert property (@(posedge clk) disable iff (reset || flush)
                    !(pop && cnt == 2'd0));

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with 1-cycle registered read feeding a 2-entry response buffer.
// A fetch is accepted only when the read stage plus buffer has room for its response.
module imem_fetch_port #(
   parameter int          XLEN      = rv32_pkg::XLEN,
   parameter int          DEPTH     = 256,
   parameter string       INIT_FILE = "",
   parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [XLEN-1:0]          req_pc,
   input  logic                     flush,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [XLEN-1:0]          rsp_instr,
   output logic [XLEN-1:0]          rsp_pc,
   output logic [1:0]               rsp_fault,
   input  logic                     ld_en,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [XLEN-1:0]          ld_data
);

   import rv32_pkg::*;

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      fault_t          fault;
   } rsp_t;

   logic [XLEN-1:0] mem [DEPTH];

   logic            inflight;
   rsp_t            rd_q;
   rsp_t            fifo_head;
   rsp_t            head;
   logic [1:0]      fifo_count;
   logic            fifo_push;
   logic            fifo_pop;
   logic            pop;
   logic            accept;
   logic [AW-1:0]   idx;
   fault_t          req_fault;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = NOP_INSTR;
   end

   always_ff @(posedge clk) begin
      if (!reset && ld_en) mem[ld_addr] <= ld_data;
   end

   assign idx       = req_pc[AW+1:2];
   assign req_fault = classify_pc(req_pc[1:0], |req_pc[XLEN-1:AW+2]);

   assign rsp_valid = (fifo_count != 2'd0) || inflight;
   assign pop       = rsp_valid && rsp_ready;
   assign req_ready = !reset &&
                      ((({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2) || pop);
   assign accept    = req_valid && req_ready;

   // The read stage feeds the output directly when the buffer is empty; otherwise
   // it parks in the buffer behind older responses unless consumed or flushed.
   assign fifo_pop  = pop && (fifo_count != 2'd0);
   assign fifo_push = inflight && !flush && !(pop && fifo_count == 2'd0);

   // A flush drops whatever was in the read stage; only this cycle's accept survives.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight <= 1'b0;
         rd_q     <= '{instr: NOP_INSTR, pc: '0, fault: FAULT_NONE};
      end else begin
         inflight <= accept;
         if (accept) begin
            rd_q.instr <= (req_fault == FAULT_NONE) ? mem[idx] : NOP_INSTR;
            rd_q.pc    <= req_pc;
            rd_q.fault <= req_fault;
         end
      end
   end

   fetch_rsp_fifo2 #(
      .W($bits(rsp_t))
   ) u_rsp_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (fifo_push),
      .push_data (rd_q),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   always_comb begin
      head      = (fifo_count != 2'd0) ? fifo_head : rd_q;
      rsp_instr = NOP_INSTR;
      rsp_pc    = '0;
      rsp_fault = FAULT_NONE;
      if (rsp_valid) begin
         rsp_instr = head.instr;
         rsp_pc    = head.pc;
         rsp_fault = head.fault;
      end
   end

   assert property (@(posedge clk) disable iff (reset)
                    ({1'b0, fifo_count} + {2'b00, inflight}) <= 3'd2);
   assert property (@(posedge clk) disable iff (reset)
                    (rsp_valid && !rsp_ready && !flush) |=>
                    (rsp_valid && $stable(rsp_pc) && $stable(rsp_instr) && $stable(rsp_fault)));

endmodule

// File: tb/tb_imem_fetch_port.sv
// Randomised scoreboard bench for imem_fetch_port with directed scenarios up front.
module tb_imem_fetch_port;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 256;
   localparam int          AW    = 8;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic            clk = 1'b0;
   logic            reset;
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_pc;
   logic            flush;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_instr;
   logic [XLEN-1:0] rsp_pc;
   logic [1:0]      rsp_fault;
   logic            ld_en;
   logic [AW-1:0]   ld_addr;
   logic [XLEN-1:0] ld_data;

   always #5 clk = ~clk;

   imem_fetch_port #(
      .XLEN(XLEN), .DEPTH(DEPTH), .INIT_FILE(""), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_pc(req_pc), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [1:0]  fault;
   } exp_t;

   exp_t        expq[$];
   logic [31:0] model_mem [DEPTH];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference behaviour: faults by plain address arithmetic, data from a word array.
   function automatic exp_t ref_fetch(input logic [31:0] pc);
      exp_t e;
      e.pc = pc;
      if (pc % 4 != 0) begin
         e.instr = NOP; e.fault = 2'd1;
      end else if (pc >= 32'(DEPTH * 4)) begin
         e.instr = NOP; e.fault = 2'd2;
      end else begin
         e.instr = model_mem[pc / 4]; e.fault = 2'd0;
      end
      return e;
   endfunction

   // Issue-side bookkeeping after the monitor has had its look at this cycle.
   task automatic tick();
      logic acc;
      @(negedge clk);
      #1;
      acc = req_valid && req_ready;
      if (reset) begin
         expq.delete();
      end else begin
         if (flush) expq.delete();
         if (acc) expq.push_back(ref_fetch(req_pc));
         if (ld_en) model_mem[ld_addr] = ld_data;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every consumed response and check held outputs stay put.
   exp_t        mon_e;
   logic        hold_prev = 1'b0;
   logic [31:0] held_instr, held_pc;
   logic [1:0]  held_fault;

   always @(negedge clk) begin
      if (hold_prev) begin
         chk("hold_valid", rsp_valid, 1);
         chk("hold_instr", rsp_instr, held_instr);
         chk("hold_pc", rsp_pc, held_pc);
         chk("hold_fault", rsp_fault, held_fault);
      end
      if (rsp_valid && rsp_ready) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got pc %0h, expected no response", rsp_pc);
         end else begin
            mon_e = expq.pop_front();
            chk("rsp_pc", rsp_pc, mon_e.pc);
            chk("rsp_instr", rsp_instr, mon_e.instr);
            chk("rsp_fault", rsp_fault, mon_e.fault);
         end
      end
      hold_prev  = rsp_valid && !rsp_ready && !flush && !reset;
      held_instr = rsp_instr;
      held_pc    = rsp_pc;
      held_fault = rsp_fault;
   end

   logic [31:0] old_word;
   int          r;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0; rsp_ready = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;

      @(posedge clk); #1;
      chk("req_ready_in_reset", req_ready, 0);
      tick(); tick();
      reset = 1'b0; #1;
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_instr", rsp_instr, NOP);
      chk("reset_rsp_pc", rsp_pc, 0);
      chk("reset_rsp_fault", rsp_fault, 0);
      chk("reset_req_ready", req_ready, 1);

      // Program image through the load port.
      for (int i = 0; i < 16; i++) begin
         ld_en = 1'b1; ld_addr = AW'(i); ld_data = $urandom;
         tick();
      end
      ld_en = 1'b0;

      // Back-to-back fetches with the consumer always ready.
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_pc = 32'(i * 4); #1;
         chk("b2b_req_ready", req_ready, 1);
         tick();
         if (i == 0) begin
            chk("first_latency_valid", rsp_valid, 1);
            chk("first_latency_pc", rsp_pc, 0);
         end
      end
      req_valid = 1'b0;
      tick(); tick();

      // Stall with two outstanding, then drain.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_pc = 32'h10; tick();
      req_pc = 32'h14; tick();
      req_pc = 32'h18; #1;
      chk("stall_req_ready", req_ready, 0);
      repeat (5) tick();
      req_valid = 1'b0; rsp_ready = 1'b1;
      repeat (3) tick();
      chk("stall_drained_queue", expq.size(), 0);
      chk("stall_drained_valid", rsp_valid, 0);

      // Fault classification.
      req_valid = 1'b1; req_pc = 32'h6; tick();
      chk("misalign_fault", rsp_fault, 1);
      chk("misalign_instr", rsp_instr, NOP);
      req_pc = 32'(DEPTH * 4); tick();
      chk("range_fault", rsp_fault, 2);
      req_pc = 32'(DEPTH * 4 + 7); tick();
      chk("misalign_beats_range", rsp_fault, 1);
      req_valid = 1'b0; tick();

      // Flush with work outstanding and a new request in the same cycle.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_pc = 32'h20; tick();
      req_pc = 32'h24; tick();
      flush = 1'b1; rsp_ready = 1'b1; req_pc = 32'h40; tick();
      flush = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0;
      chk("flush_next_valid", rsp_valid, 1);
      chk("flush_next_pc", rsp_pc, 32'h40);
      rsp_ready = 1'b1;
      tick(); tick();
      chk("flush_no_leftover", rsp_valid, 0);

      // Load concurrent with a fetch of the same word returns the old word.
      old_word = model_mem[3];
      req_valid = 1'b1; req_pc = 32'hC;
      ld_en = 1'b1; ld_addr = AW'(3); ld_data = 32'hDEADBEEF;
      tick();
      ld_en = 1'b0;
      chk("load_rbw_old", rsp_instr, old_word);
      tick();
      chk("load_refetch_new", rsp_instr, 32'hDEADBEEF);
      req_valid = 1'b0; tick();

      // Reset with a full buffer; a load during reset is ignored.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_pc = 32'h0; tick();
      req_pc = 32'h4; tick();
      req_valid = 1'b0; tick();
      reset = 1'b1; ld_en = 1'b1; ld_addr = AW'(5); ld_data = 32'hBAD0BAD0;
      tick();
      chk("rst_full_valid", rsp_valid, 0);
      chk("rst_full_instr", rsp_instr, NOP);
      chk("rst_full_pc", rsp_pc, 0);
      reset = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
      req_valid = 1'b1; req_pc = 32'hC; tick();
      chk("load_survives_reset", rsp_instr, 32'hDEADBEEF);
      req_pc = 32'h14; tick();
      chk("load_ignored_in_reset", rsp_instr, model_mem[5]);
      req_valid = 1'b0; tick();

      // Randomised traffic.
      for (int n = 0; n < 2000; n++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 19);
         if (r == 0)      req_pc = $urandom;
         else if (r == 1) req_pc = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
         else if (r == 2) req_pc = 32'(DEPTH * 4 + $urandom_range(0, 63) * 4);
         else             req_pc = 32'($urandom_range(0, 31) * 4);
         rsp_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         reset     = ($urandom_range(0, 99) == 0);
         ld_en     = ($urandom_range(0, 9) == 0);
         ld_addr   = AW'($urandom_range(0, 31));
         ld_data   = $urandom;
         tick();
      end

      req_valid = 1'b0; flush = 1'b0; reset = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
      for (int n = 0; n < 10 && expq.size() != 0; n++) tick();
      chk("final_queue_empty", expq.size(), 0);
      tick();
      chk("final_rsp_idle", rsp_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
